// File: rtl/sysbus_arbiter_if.sv
// One Sysbus request/response channel pair. The master drives requests and
// consumes responses; the slave accepts requests and returns responses.
interface sysbus_arbiter_if #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13
);
    logic                      reqcyc;
    logic [BUS_DATA_WIDTH-1:0] req;
    logic [BUS_TAG_WIDTH-1:0]  reqtag;
    logic                      reqack;
    logic                      respcyc;
    logic [BUS_DATA_WIDTH-1:0] resp;
    logic [BUS_TAG_WIDTH-1:0]  resptag;
    logic                      respack;

    modport master (
        output reqcyc, req, reqtag, respack,
        input  reqack, respcyc, resp, resptag
    );

    modport slave (
        input  reqcyc, req, reqtag, respack,
        output reqack, respcyc, resp, resptag
    );
endinterface

// File: rtl/sysbus_arbiter.sv
// Round-robin arbiter sharing one Sysbus port between instruction fetch (p0)
// and load/store (p1); the grant is held until the full burst completes.
module sysbus_arbiter #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BEATS          = 8
) (
    input  logic             clk,
    input  logic             reset,
    sysbus_arbiter_if.slave  p0,
    sysbus_arbiter_if.slave  p1,
    sysbus_arbiter_if.master bus
);
    localparam int CW = $clog2(BEATS) + 1;

    typedef enum logic [1:0] {IDLE, REQ, RDATA, WDATA} state_t;

    state_t        state, state_n;
    logic          owner, owner_n;
    logic          last_grant, last_grant_n;
    logic [CW-1:0] cnt, cnt_n;

    logic                      own_reqcyc;
    logic [BUS_DATA_WIDTH-1:0] own_req;
    logic [BUS_TAG_WIDTH-1:0]  own_reqtag;
    logic                      own_respack;
    logic                      fwd_req;
    logic                      fwd_resp;
    logic                      beat_last;

    assign own_reqcyc  = owner ? p1.reqcyc  : p0.reqcyc;
    assign own_req     = owner ? p1.req     : p0.req;
    assign own_reqtag  = owner ? p1.reqtag  : p0.reqtag;
    assign own_respack = owner ? p1.respack : p0.respack;
    assign beat_last   = (cnt == CW'(BEATS - 1));

    // Forwarding is masked during reset so no beat is acked in the reset cycle.
    assign fwd_req  = !reset && (state == REQ || state == WDATA);
    assign fwd_resp = !reset && (state == RDATA);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= '0;
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            last_grant <= last_grant_n;
            cnt        <= cnt_n;
        end
    end

    always_comb begin
        state_n      = state;
        owner_n      = owner;
        last_grant_n = last_grant;
        cnt_n        = cnt;
        case (state)
            IDLE: begin
                if (p0.reqcyc || p1.reqcyc) begin
                    owner_n      = (p0.reqcyc && p1.reqcyc) ? ~last_grant : p1.reqcyc;
                    last_grant_n = owner_n;
                    state_n      = REQ;
                end
            end
            REQ: begin
                if (!own_reqcyc) begin
                    state_n = IDLE;
                end else if (bus.reqack) begin
                    cnt_n   = '0;
                    state_n = own_reqtag[BUS_TAG_WIDTH-1] ? RDATA : WDATA;
                end
            end
            RDATA: begin
                if (bus.respcyc && own_respack) begin
                    if (beat_last) state_n = IDLE;
                    else           cnt_n   = cnt + 1'b1;
                end
            end
            WDATA: begin
                if (own_reqcyc && bus.reqack) begin
                    if (beat_last) state_n = IDLE;
                    else           cnt_n   = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        bus.reqcyc  = 1'b0;
        bus.req     = '0;
        bus.reqtag  = '0;
        bus.respack = 1'b0;
        p0.reqack   = 1'b0;
        p1.reqack   = 1'b0;
        p0.respcyc  = 1'b0;
        p0.resp     = '0;
        p0.resptag  = '0;
        p1.respcyc  = 1'b0;
        p1.resp     = '0;
        p1.resptag  = '0;
        if (fwd_req) begin
            bus.reqcyc = own_reqcyc;
            bus.req    = own_req;
            bus.reqtag = own_reqtag;
            if (owner) p1.reqack = bus.reqack;
            else       p0.reqack = bus.reqack;
        end
        if (fwd_resp) begin
            bus.respack = own_respack;
            if (owner) begin
                p1.respcyc = bus.respcyc;
                p1.resp    = bus.resp;
                p1.resptag = bus.resptag;
            end else begin
                p0.respcyc = bus.respcyc;
                p0.resp    = bus.resp;
                p0.resptag = bus.resptag;
            end
        end
    end
endmodule
